// File: rtl/if_stage_pipe_if.sv
// if_stage_pipe_if: bus between the instruction-fetch stage and its surroundings.
// It carries the hazard and redirect inputs, the instruction-memory port and the
// IF/ID register outputs.
//   master (fetch stage): in  freez, branch_taken, branch_addr, imem_rdata
//                         out imem_addr, pc_out, instr_out, valid_out, freez_cnt
//   slave  (environment): the same signals with the directions reversed
interface if_stage_pipe_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              freez;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [ADDR_W-1:0] pc_out;
  logic [31:0]       instr_out;
  logic              valid_out;
  logic [15:0]       freez_cnt;

  modport master (
    input  freez, branch_taken, branch_addr, imem_rdata,
    output imem_addr, pc_out, instr_out, valid_out, freez_cnt
  );

  modport slave (
    output freez, branch_taken, branch_addr, imem_rdata,
    input  imem_addr, pc_out, instr_out, valid_out, freez_cnt
  );
endinterface

// File: rtl/if_stage_pipe.sv
// if_stage_pipe: instruction-fetch stage and IF/ID pipeline register.
// It holds the PC and presents it combinationally as the instruction-memory
// address. Each cycle it captures {instruction, PC+4, valid} into IF/ID.
//   clk   : core clock; all state changes on the rising edge
//   rst   : synchronous reset, active-high; overrides every other input
//   bus   : if_stage_pipe_if.master
//           freez               stall: hold PC and IF/ID, do not sample imem
//           branch_taken/_addr  redirect PC to the word-aligned target, flush IF/ID
//           imem_addr/_rdata    instruction memory, zero-latency read
//           pc_out/instr_out/valid_out  IF/ID register
//           freez_cnt           saturating count of freeze cycles
// Optional feature macro: FREEZ_CNT_EN. When it is defined, freez_cnt counts.
// When it is undefined, freez_cnt is tied to zero.
// Priority at every edge: rst > branch_taken > freez > normal fetch.
module if_stage_pipe #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  if_stage_pipe_if.master bus
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_out;
  logic [31:0]       r_instr;
  logic              r_valid;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_branch_tgt;

  // The addition wraps modulo 2^ADDR_W, so the address after the top word is 0.
  assign w_pc_plus4   = r_pc + ADDR_W'(4);
  // Clear the low two bits so that the target is word-aligned.
  assign w_branch_tgt = bus.branch_addr & ~ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_pc_out <= '0;
      r_instr  <= NOP_INSTR;
      r_valid  <= 1'b0;
    end else if (bus.branch_taken) begin
      // The word at the old PC is dropped. IF/ID becomes one bubble.
      r_pc     <= w_branch_tgt;
      r_pc_out <= '0;
      r_instr  <= NOP_INSTR;
      r_valid  <= 1'b0;
    end else if (!bus.freez) begin
      r_pc     <= w_pc_plus4;
      r_pc_out <= w_pc_plus4;
      r_instr  <= bus.imem_rdata;
      r_valid  <= 1'b1;
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.pc_out    = r_pc_out;
  assign bus.instr_out = r_instr;
  assign bus.valid_out = r_valid;

`ifdef FREEZ_CNT_EN
  logic [15:0] r_freez_cnt;

  // The counter advances only on real stall cycles. A freeze that collides with
  // a branch is overridden and is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_freez_cnt <= '0;
    end else if (bus.freez && !bus.branch_taken && (r_freez_cnt != '1)) begin
      r_freez_cnt <= r_freez_cnt + 16'd1;
    end
  end

  assign bus.freez_cnt = r_freez_cnt;
`else
  assign bus.freez_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
// tb_if_stage_pipe: scoreboard bench for if_stage_pipe.
// A driver applies directed vectors on the falling edge and queues the
// hand-computed IF/ID and imem_addr values due after the next rising edge.
// A monitor pops each entry shortly after that edge and compares it.
// Instance dut has RESET_PC=0. Instance dut2 has RESET_PC=FFFF_FFF8 and covers
// address wrap-around.
module tb_if_stage_pipe;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FREEZ_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst2;

  if_stage_pipe_if #(.ADDR_W(32)) bus ();
  if_stage_pipe_if #(.ADDR_W(32)) bus2 ();

  if_stage_pipe #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  if_stage_pipe #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  // Instruction memory model: word = addr ^ A5A5_0000, zero latency.
  assign bus.imem_rdata     = bus.imem_addr ^ 32'hA5A5_0000;
  assign bus2.imem_rdata    = bus2.imem_addr ^ 32'hA5A5_0000;
  assign bus2.freez         = 1'b0;
  assign bus2.branch_taken  = 1'b0;
  assign bus2.branch_addr   = 32'h0;

  typedef struct {
    string       nm;
    int          which;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        v;
    logic [15:0] cnt;
    bit          chk_cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic int K(input int n);
    return CNT_ON ? n : 0;
  endfunction

  function automatic void chk(input string nm, input string fld,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endfunction

  // Main instance vector: inputs for one cycle, then the state expected after the edge.
  // If ec is negative, the counter is not checked.
  task automatic step(input string nm, input bit r, input bit f, input bit b,
                      input logic [31:0] ba, input logic [31:0] ea,
                      input logic [31:0] ep, input logic [31:0] ei,
                      input logic ev, input int ec);
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.freez        = f;
    bus.branch_taken = b;
    bus.branch_addr  = ba;
    e = '{nm, 0, ea, ep, ei, ev, 16'(ec), (ec >= 0)};
    q.push_back(e);
  endtask

  task automatic step2(input string nm, input bit r, input logic [31:0] ea,
                       input logic [31:0] ep, input logic [31:0] ei, input logic ev);
    exp_t e;
    @(negedge clk);
    rst2 = r;
    e = '{nm, 1, ea, ep, ei, ev, 16'h0, 1'b0};
    q.push_back(e);
  endtask

  // Monitor: compares the queued expectation just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.which == 0) begin
          chk(e.nm, "imem_addr", bus.imem_addr, e.addr);
          chk(e.nm, "pc_out",    bus.pc_out,    e.pc);
          chk(e.nm, "instr_out", bus.instr_out, e.instr);
          chk(e.nm, "valid_out", 32'(bus.valid_out), 32'(e.v));
          if (e.chk_cnt) chk(e.nm, "freez_cnt", 32'(bus.freez_cnt), 32'(e.cnt));
        end else begin
          chk(e.nm, "imem_addr", bus2.imem_addr, e.addr);
          chk(e.nm, "pc_out",    bus2.pc_out,    e.pc);
          chk(e.nm, "instr_out", bus2.instr_out, e.instr);
          chk(e.nm, "valid_out", 32'(bus2.valid_out), 32'(e.v));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus.freez = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = '0;

    //    name       rst f  b  baddr         imem_addr     pc_out        instr         v     cnt
    step("rst0",      1, 0, 0, 32'h0,       32'h0,       32'h0,       NOP,          1'b0, 0);
    step("rst1",      1, 0, 0, 32'h0,       32'h0,       32'h0,       NOP,          1'b0, 0);
    step("run0",      0, 0, 0, 32'h0,       32'h4,       32'h4,       32'hA5A50000, 1'b1, 0);
    step("run1",      0, 0, 0, 32'h0,       32'h8,       32'h8,       32'hA5A50004, 1'b1, -1);
    step("run2",      0, 0, 0, 32'h0,       32'hC,       32'hC,       32'hA5A50008, 1'b1, -1);
    step("run3",      0, 0, 0, 32'h0,       32'h10,      32'h10,      32'hA5A5000C, 1'b1, -1);
    step("frz0",      0, 1, 0, 32'h0,       32'h10,      32'h10,      32'hA5A5000C, 1'b1, K(1));
    step("frz1",      0, 1, 0, 32'h0,       32'h10,      32'h10,      32'hA5A5000C, 1'b1, K(2));
    step("frz2",      0, 1, 0, 32'h0,       32'h10,      32'h10,      32'hA5A5000C, 1'b1, K(3));
    step("frz_rel",   0, 0, 0, 32'h0,       32'h14,      32'h14,      32'hA5A50010, 1'b1, K(3));
    step("run4",      0, 0, 0, 32'h0,       32'h18,      32'h18,      32'hA5A50014, 1'b1, -1);
    step("run5",      0, 0, 0, 32'h0,       32'h1C,      32'h1C,      32'hA5A50018, 1'b1, -1);
    step("run6",      0, 0, 0, 32'h0,       32'h20,      32'h20,      32'hA5A5001C, 1'b1, -1);
    step("br_flush",  0, 0, 1, 32'h103,     32'h100,     32'h0,       NOP,          1'b0, -1);
    step("br_tgt",    0, 0, 0, 32'h0,       32'h104,     32'h104,     32'hA5A50100, 1'b1, -1);
    step("br_vs_frz", 0, 1, 1, 32'h200,     32'h200,     32'h0,       NOP,          1'b0, K(3));
    step("br_vs_nx",  0, 0, 0, 32'h0,       32'h204,     32'h204,     32'hA5A50200, 1'b1, K(3));
    step("b2b_0",     0, 0, 1, 32'h300,     32'h300,     32'h0,       NOP,          1'b0, -1);
    step("b2b_1",     0, 0, 1, 32'h40A,     32'h408,     32'h0,       NOP,          1'b0, -1);
    step("b2b_nx",    0, 0, 0, 32'h0,       32'h40C,     32'h40C,     32'hA5A50408, 1'b1, -1);
    step("frz3",      0, 1, 0, 32'h0,       32'h40C,     32'h40C,     32'hA5A50408, 1'b1, K(4));
    step("frz4",      0, 1, 0, 32'h0,       32'h40C,     32'h40C,     32'hA5A50408, 1'b1, K(5));
    step("rst_frz",   1, 1, 0, 32'h0,       32'h0,       32'h0,       NOP,          1'b0, 0);
    step("post_rst",  0, 1, 0, 32'h0,       32'h0,       32'h0,       NOP,          1'b0, K(1));
    step("post_run",  0, 0, 0, 32'h0,       32'h4,       32'h4,       32'hA5A50000, 1'b1, K(1));

    // Wrap-around on the second instance.
    step2("wrap_rst", 1, 32'hFFFFFFF8, 32'h0,        NOP,          1'b0);
    step2("wrap0",    0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h5A5AFFF8, 1'b1);
    step2("wrap1",    0, 32'h00000000, 32'h00000000, 32'h5A5AFFFC, 1'b1);
    step2("wrap2",    0, 32'h00000004, 32'h00000004, 32'hA5A50000, 1'b1);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the 5-stage core. It holds the PC, drives the instruction-memory address, and captures the fetched word, PC+4 and a valid bit into the IF/ID register. It consumes the freeze output of the hazard detector, which stalls the PC and IF/ID. It also consumes the branch-taken/target pair from EXE, which redirects the PC and flushes IF/ID. Its outputs feed the ID stage, which produces the src1/src2 register numbers the hazard detector compares.

Parameters:
ADDR_W, 32, PC and address width in bits
RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)
NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush or reset

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
freez  in  1  stall request from hazard detection; holds PC and IF/ID
branch_taken  in  1  EXE-stage branch resolved taken; redirect and flush
branch_addr  in  ADDR_W  branch target from EXE
imem_addr  out  ADDR_W  instruction memory address, combinational = pc
imem_rdata  in  32  instruction word, asynchronous read of imem_addr
pc_out  out  ADDR_W  IF/ID: PC+4 of captured instruction
instr_out  out  32  IF/ID: captured instruction
valid_out  out  1  IF/ID: 1 = real instruction, 0 = bubble
freez_cnt  out  16  freeze-cycle count (see Optional Feature)

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC; pc_out<=0; instr_out<=NOP_INSTR; valid_out<=0; freez_cnt<=0. rst overrides every other input.
- Reset mid-operation discards any pending freeze or redirect. The first real instruction appears on valid_out one cycle after rst is deasserted.
- imem_addr = pc always, including during freeze. Zero-cycle memory latency is assumed by the interface.
- Priority at each edge, rst=0: branch_taken > freez > normal.
- branch_taken=1, freez ignored:
  - pc <= {branch_addr[ADDR_W-1:2],2'b00}; the low 2 bits are forced to zero.
  - IF/ID flushed: instr_out<=NOP_INSTR, pc_out<=0, valid_out<=0.
  - The instruction at the old pc is dropped.
- freez=1, branch_taken=0: pc, pc_out, instr_out and valid_out all hold their values. imem_rdata is not sampled.
- Normal (freez=0, branch_taken=0):
  - pc <= pc+4, modulo 2^ADDR_W. Wrap from max aligned address to 0 is silent.
  - pc_out <= pc+4; instr_out <= imem_rdata; valid_out <= 1.
- Redirect latency:
  - Branch target word is on imem_addr in the cycle after branch_taken.
  - It reaches instr_out one cycle later.
  - Exactly one IF/ID bubble per taken branch from this block.
- Back-to-back branch_taken on consecutive cycles: each redirect wins. pc follows the most recent branch_addr, and valid_out stays 0 throughout.
- Freeze released: the fetch resumes at the held pc; no instruction is lost or duplicated.
- No combinational path from freez or branch_taken to any output. All outputs except imem_addr are registered; imem_addr depends only on the pc register.

Optional Feature:
Macro FREEZ_CNT_EN.
- Defined: freez_cnt increments by 1 on each edge where rst=0, freez=1 and branch_taken=0.
  - It saturates at 16'hFFFF and does not wrap.
  - It is cleared only by rst.
- Undefined: freez_cnt is tied to 16'h0000, no counter flops exist, and the port stays present.

Test Plan:
- Reset then run: rst for 2 cycles, imem returns word = addr ^ 32'hA5A5_0000.
  - valid_out=0 and pc_out=0 first.
  - Next cycles: instr_out=32'hA5A5_0000, pc_out=4; then instr_out=32'hA5A5_0004, pc_out=8.
- Freeze hold: run to pc=0x10, assert freez 3 cycles.
  - imem_addr stays 0x10; instr_out/pc_out unchanged for 3 cycles.
  - After release: instr_out = word@0x10, pc_out=0x14.
  - With FREEZ_CNT_EN: freez_cnt=3.
- Branch flush: at pc=0x20 pulse branch_taken with branch_addr=0x103.
  - Next cycle: imem_addr=0x100, valid_out=0, instr_out=NOP_INSTR.
  - Following cycle: instr_out = word@0x100, pc_out=0x104.
- Branch vs freeze collision: freez=1 and branch_taken=1 with branch_addr=0x200 in the same cycle.
  - Result: pc=0x200 and IF/ID flushed, i.e. the branch wins.
- Wrap-around: RESET_PC=32'hFFFF_FFF8, run 3 cycles.
  - imem_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - pc_out for the FFFF_FFFC word = 0.
- Reset mid-freeze: freez held high, counter at 5, assert rst.
  - pc=RESET_PC, valid_out=0, freez_cnt=0, even though freez is still 1.
